// File: rtl/jk_bank_sequencer_if.sv
// ---------------------------------------------------------------------------
// jk_bank_sequencer_if
// Command channel of the JK bank sequencer: one command at a time over a
// valid/ready handshake.
//   Cmd_Valid  master -> slave  command present
//   Cmd_Ready  slave  -> master controller can accept a command
//   Cmd_Op     master -> slave  3-bit opcode
//   Cmd_Data   master -> slave  load value / toggle mask (WIDTH bits)
//   Cmd_Count  master -> slave  number of count steps (CNT_W bits)
// ---------------------------------------------------------------------------
interface jk_bank_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) ();
    logic             Cmd_Valid;
    logic             Cmd_Ready;
    logic [2:0]       Cmd_Op;
    logic [WIDTH-1:0] Cmd_Data;
    logic [CNT_W-1:0] Cmd_Count;

    modport master (
        output Cmd_Valid,
        output Cmd_Op,
        output Cmd_Data,
        output Cmd_Count,
        input  Cmd_Ready
    );

    modport slave (
        input  Cmd_Valid,
        input  Cmd_Op,
        input  Cmd_Data,
        input  Cmd_Count,
        output Cmd_Ready
    );
endinterface

// File: rtl/jk_bank_sequencer.sv
// ---------------------------------------------------------------------------
// jk_bank_sequencer
// Command-driven controller for an external bank of WIDTH negedge-clocked JK
// flip-flops. J/K are registered on posedge Clk; the bank updates on the
// following negedge, so Q_fb is settled by the next posedge and a count step
// takes one cycle.
//
// Ports:
//   Clk        system clock, all state updates on posedge
//   Reset      synchronous active-high reset (aborts the command in flight)
//   cmd        command channel (slave modport of jk_bank_sequencer_if)
//   Q_fb       Q outputs of the JK bank
//   J, K       registered drive vectors to the bank
//   Busy       high in EXEC and DONE
//   Done       one-cycle pulse on command completion
//   Wrap       one-cycle pulse on counter wrap (saturation flag when enabled)
//   Err        one-cycle pulse on illegal opcode
//
// Optional feature macro: JKC_SATURATE_EN
//   defined   - a count step that would wrap is suppressed and ends the command
//   undefined - modulo 2^WIDTH counting, Wrap pulses on every wrap
// ---------------------------------------------------------------------------
module jk_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    jk_bank_sequencer_if.slave cmd,
    input  logic [WIDTH-1:0]   Q_fb,
    output logic [WIDTH-1:0]   J,
    output logic [WIDTH-1:0]   K,
    output logic               Busy,
    output logic               Done,
    output logic               Wrap,
    output logic               Err
);

    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_CLEAR  = 3'b001;
    localparam logic [2:0] OP_LOAD   = 3'b010;
    localparam logic [2:0] OP_TOGGLE = 3'b011;
    localparam logic [2:0] OP_UP     = 3'b100;
    localparam logic [2:0] OP_DOWN   = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r;
    logic             dir_r;      // 1 = counting down
    logic [CNT_W-1:0] cnt_r;      // steps still to issue after the current one
    logic [WIDTH-1:0] j_r;
    logic [WIDTH-1:0] k_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic             wrap_r;
    logic             err_r;

    logic             step_down_s;
    logic [WIDTH-1:0] step_vec_s;  // bits that toggle for one count step
    logic             step_wrap_s; // this step crosses the all-ones/all-zeros boundary
    logic [WIDTH-1:0] step_jk_s;   // drive actually issued for the step
    logic             step_stop_s; // step suppressed, command ends

    // Count-step vector: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin : step_logic
        logic ones_v;
        logic zeros_v;
        ones_v     = 1'b1;
        zeros_v    = 1'b1;
        step_vec_s = {WIDTH{1'b0}};
        // On the accept edge the direction comes straight from the opcode.
        if (state_r == ST_IDLE) begin
            step_down_s = cmd.Cmd_Op[0];
        end else begin
            step_down_s = dir_r;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (step_down_s) begin
                step_vec_s[i] = zeros_v;
            end else begin
                step_vec_s[i] = ones_v;
            end
            ones_v  = ones_v & Q_fb[i];
            zeros_v = zeros_v & ~Q_fb[i];
        end
        if (step_down_s) begin
            step_wrap_s = zeros_v;
        end else begin
            step_wrap_s = ones_v;
        end
`ifdef JKC_SATURATE_EN
        if (step_wrap_s) begin
            step_jk_s   = {WIDTH{1'b0}};
            step_stop_s = 1'b1;
        end else begin
            step_jk_s   = step_vec_s;
            step_stop_s = 1'b0;
        end
`else
        step_jk_s   = step_vec_s;
        step_stop_s = 1'b0;
`endif
    end

    // Command FSM with registered drive vectors and status pulses.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            dir_r   <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            j_r     <= {WIDTH{1'b0}};
            k_r     <= {WIDTH{1'b0}};
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            wrap_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    j_r    <= {WIDTH{1'b0}};
                    k_r    <= {WIDTH{1'b0}};
                    done_r <= 1'b0;
                    wrap_r <= 1'b0;
                    err_r  <= 1'b0;
                    cnt_r  <= {CNT_W{1'b0}};
                    if (cmd.Cmd_Valid) begin
                        // The first drive is issued on the accept edge itself.
                        state_r <= ST_EXEC;
                        dir_r   <= cmd.Cmd_Op[0];
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                        case (cmd.Cmd_Op)
                            OP_HOLD: begin
                                j_r <= {WIDTH{1'b0}};
                                k_r <= {WIDTH{1'b0}};
                            end
                            OP_CLEAR: begin
                                j_r <= {WIDTH{1'b0}};
                                k_r <= {WIDTH{1'b1}};
                            end
                            OP_LOAD: begin
                                j_r <= cmd.Cmd_Data;
                                k_r <= ~cmd.Cmd_Data;
                            end
                            OP_TOGGLE: begin
                                j_r <= cmd.Cmd_Data;
                                k_r <= cmd.Cmd_Data;
                            end
                            OP_UP, OP_DOWN: begin
                                if (cmd.Cmd_Count != {CNT_W{1'b0}}) begin
                                    j_r    <= step_jk_s;
                                    k_r    <= step_jk_s;
                                    wrap_r <= step_wrap_s;
                                    if (step_stop_s) begin
                                        cnt_r <= {CNT_W{1'b0}};
                                    end else begin
                                        cnt_r <= cmd.Cmd_Count - {{(CNT_W-1){1'b0}}, 1'b1};
                                    end
                                end else begin
                                    j_r <= {WIDTH{1'b0}};
                                    k_r <= {WIDTH{1'b0}};
                                end
                            end
                            default: begin
                                // Illegal opcodes behave as HOLD and flag Err.
                                j_r   <= {WIDTH{1'b0}};
                                k_r   <= {WIDTH{1'b0}};
                                err_r <= 1'b1;
                            end
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    err_r <= 1'b0;
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_DONE;
                        j_r     <= {WIDTH{1'b0}};
                        k_r     <= {WIDTH{1'b0}};
                        done_r  <= 1'b1;
                        wrap_r  <= 1'b0;
                    end else begin
                        j_r    <= step_jk_s;
                        k_r    <= step_jk_s;
                        wrap_r <= step_wrap_s;
                        if (step_stop_s) begin
                            cnt_r <= {CNT_W{1'b0}};
                        end else begin
                            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    j_r     <= {WIDTH{1'b0}};
                    k_r     <= {WIDTH{1'b0}};
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    wrap_r  <= 1'b0;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign cmd.Cmd_Ready = ready_r;
    assign J             = j_r;
    assign K             = k_r;
    assign Busy          = busy_r;
    assign Done          = done_r;
    assign Wrap          = wrap_r;
    assign Err           = err_r;

endmodule

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
- Command-driven controller for an external bank of WIDTH negedge-clocked JK flip-flops.
- Accepts one command at a time over a valid/ready handshake.
- Registers per-bit J/K drive vectors on the posedge of Clk and reads the bank's Q outputs back as feedback.
- Supports hold, clear, load, toggle and multi-step synchronous up/down counting. The bank then serves as a general-purpose register/counter.

Parameters:
- WIDTH, 4, number of JK flip-flops in the driven bank.
- CNT_W, 8, width of the step-count field for count commands.

Ports:
- Clk  input  1  system clock; all state updates on posedge.
- Reset  input  1  synchronous active-high reset.
- Cmd_Valid  input  1  command present.
- Cmd_Ready  output  1  controller can accept a command.
- Cmd_Op  input  3  opcode.
- Cmd_Data  input  WIDTH  load value / toggle mask.
- Cmd_Count  input  CNT_W  number of count steps.
- Q_fb  input  WIDTH  Q outputs of the JK bank.
- J  output  WIDTH  registered J drive to bank.
- K  output  WIDTH  registered K drive to bank.
- Busy  output  1  high in EXEC and DONE.
- Done  output  1  one-cycle pulse on command completion.
- Wrap  output  1  one-cycle pulse on counter wrap (saturation when the macro is set).
- Err  output  1  one-cycle pulse on illegal opcode.

Behaviour:
- Timing contract: J/K registered at posedge t, bank updates at negedge t+0.5, Q_fb is stable at posedge t+1. One count step therefore takes one cycle.
- Reset (synchronous, any state, including mid-command): state=IDLE, J=0, K=0, Busy=0, Done=0, Wrap=0, Err=0, step counter=0.
  - The command in flight is aborted.
  - The controller does not drive the bank's own reset.
- States:
  - IDLE: Cmd_Ready=1, J=K=0. A command is accepted on a posedge with Cmd_Valid && Cmd_Ready. Cmd_Op, Cmd_Data and Cmd_Count are latched, and the state moves to EXEC.
  - EXEC: Cmd_Ready=0, Busy=1.
  - DONE: J=K=0, Done=1 for exactly one cycle, Cmd_Ready=0. Next state is IDLE.
- Opcodes. Single-cycle ops (HOLD, CLEAR, LOAD, TOGGLE) spend exactly one cycle in EXEC.
  - 000 HOLD: J=0, K=0 for one EXEC cycle.
  - 001 CLEAR: J=0, K=all ones.
  - 010 LOAD: J=Data, K=~Data.
  - 011 TOGGLE: J=K=Data. Mask 0 is legal and is a no-op.
  - 100 UP: N=Cmd_Count steps. Each step sets J[i]=K[i]=1 iff Q_fb[i-1:0] are all 1 (bit 0 always toggles).
  - 101 DOWN: N steps. Each step sets J[i]=K[i]=1 iff Q_fb[i-1:0] are all 0.
  - 110/111: executed as HOLD; Err pulses in the EXEC cycle.
- Count ops:
  - Step vectors are computed combinationally from Q_fb at each EXEC posedge, then registered.
  - Internal step counter is CNT_W bits, loaded with N and decremented per step. EXEC exits to DONE after the Nth step is issued.
  - N=0: zero steps, EXEC lasts one cycle with J=K=0, then DONE.
  - N counts up to 2^CNT_W-1 are legal.
- Wrap: pulses in the cycle a step is issued with Q_fb all ones (UP) or all zeros (DOWN).
- Latency:
  - Single-cycle op accepted at edge e: J/K valid e→e+1, Done high e+1→e+2, Cmd_Ready returns at e+2.
  - Count op: Done follows N (min 1) EXEC cycles.
- Simultaneity:
  - Cmd_Valid is ignored while Busy.
  - Reset takes priority over acceptance on the same edge.
  - Back-to-back commands are separated by at least one IDLE cycle (the Ready cycle).

Optional Feature:
- JKC_SATURATE_EN.
- Defined: a count step that would wrap is suppressed. J=K=0 for that cycle, remaining steps are discarded, the next state is DONE, and Wrap pulses as a saturation flag.
- Undefined: modulo 2^WIDTH wrap, counting continues, and Wrap pulses each wrap.

Test Plan:
- Reset asserted mid-UP (N=10 after 3 steps) → next posedge J=K=0, Busy=0, Cmd_Ready=1; Q_fb is unchanged thereafter.
- LOAD Data=4'b1010 then CLEAR → bank reads 1010 after the first command and 0000 after the second; Done pulses once per command; Cmd_Ready is low for 2 cycles each.
- LOAD 4'b1101, UP N=5 → bank sequence 1110, 1111, 0000, 0001, 0010; Wrap pulses once, on the 1111→0000 step; Done pulses after the 5th step.
- LOAD 4'b0001, DOWN N=3 → 0000, 1111, 1110; Wrap pulses on the second step.
- Cmd_Op=3'b111 with Data=4'hF → J=K=0, bank is unchanged, Err and Done each pulse once; also UP N=0 → no bank change, Done pulses, Wrap stays 0.
- With JKC_SATURATE_EN: LOAD 4'b1110, UP N=4 → bank stops at 1111, Wrap pulses, Done pulses 2 cycles after the first step issues.
